pixel_frame_buffer: RTL and testbench
=====================================

# pixel_frame_buffer

Double-buffered grayscale frame store feeding the pixel driver stage of the NX4 LED panel. It accepts per-channel 12-bit grayscale writes from the pattern or host side over a valid/ready handshake. It holds one displayed frame and one frame being filled, and serves the displayed frame bit-by-bit to the driver's 12 serial lanes (6 left, 6 right). Banks swap only on the driver's frame-sync pulse, at the XLAT/BLANK boundary, so the panel never shows a torn frame.

## Interface
- `LANES`, 12: serial output lanes; lanes 0–5 feed left SIN 1–6, lanes 6–11 feed right SIN 1–6.
- `CHANNELS`, 16: grayscale channels per lane.
- `GS_BITS`, 12: grayscale depth.
- `clock`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `wr_valid`  in  1  write request.
- `wr_ready`  out  1  buffer can accept a write.
- `wr_lane`  in  4  target lane, 0–11.
- `wr_channel`  in  4  target channel, 0–15.
- `wr_data`  in  12  grayscale value.
- `wr_last`  in  1  this write completes the frame and commits it.
- `frame_sync`  in  1  one-cycle pulse from the driver at each latch boundary.
- `rd_channel`  in  4  channel the driver is shifting.
- `rd_bit`  in  4  bit index, 11 = MSB first, 0–11 valid.
- `rd_lanes`  out  12  selected bit of each lane from the display bank.
- `frame_count`  out  16  completed bank swaps, wraps.
- `repeat_count`  out  8  frame_syncs that arrived with no pending frame; saturates at 255.
- `wr_error`  out  1  sticky flag: a write targeted lane 12–15.

## Operation
- Two banks. `disp_sel` names the display bank; the write bank is the other one. Each bank holds LANES×CHANNELS×GS_BITS bits.
- The ownership FSM has two states:
  - FILL: `wr_ready`=1. Writes update the write bank.
  - PENDING: entered when a write with `wr_last` is accepted. `wr_ready`=0.
- FSM transitions:
  - PENDING & `frame_sync`: toggle `disp_sel`, increment `frame_count`, set `frame_valid`=1, go to FILL.
  - FILL & `frame_sync`: no swap; `repeat_count` increments with saturation.
- A write is accepted when `wr_valid & wr_ready`.
  - Lane ≥ 12: data is dropped and `wr_error` is set. `wr_last` still commits.
  - Unwritten locations in the write bank keep their previous contents. The buffer does no clearing.
- Read path:
  - `rd_lanes[i]` = bit `rd_bit` of (lane i, channel `rd_channel`) in the display bank.
  - `rd_bit` 12–15 yields 0.
  - While `frame_valid`=0, `rd_lanes` is forced to 0 so the panel stays dark after reset.
- Reset values: FSM FILL, `disp_sel`=0, `frame_valid`=0, `wr_ready`=0 while `reset_n`=0, `rd_lanes`=0, `frame_count`=0, `repeat_count`=0, `wr_error`=0. Memory contents are not reset.

## Timing
- Write: the accepted datum is stored at the accepting edge. `wr_ready` falls on the cycle after the `wr_last` acceptance.
- Swap:
  - `frame_sync` is sampled against the registered state. If `wr_last` is accepted and `frame_sync` arrives in the same cycle, there is no swap and `repeat_count` increments. The swap happens at the next `frame_sync`.
  - After a swap, `disp_sel`, `frame_count` and `wr_ready`=1 are all visible on the cycle after the `frame_sync` edge.
- Read latency is 1 cycle: `rd_lanes` is registered from the `rd_channel`/`rd_bit` presented on the previous edge. A read issued in the `frame_sync` cycle returns data from the old bank. The next read returns data from the new bank.
- `frame_count` wraps from 0xFFFF to 0. `repeat_count` holds at 255.
- When `reset_n` is asserted mid-frame, it takes effect at the next edge:
  - a pending frame is discarded;
  - the first `frame_sync` after reset does not swap.

## Structure
- The shared package `nx4_pkg` holds `LANES`, `CHANNELS` and `GS_BITS`, and the lane-to-SIN mapping constants that the driver stage also uses.
- One sub-module, `gs_lane_ram`, is instantiated per lane. It holds 2 banks × 16 × 12 bits, with a synchronous write port and a registered read port that returns the full 12-bit word. The top level does the bit select, the `frame_valid` gating, the FSM and the counters.

## Test plan
- Reset, write lane 0 ch 0 = 0xFFF with `wr_last`, then `frame_sync` → `rd_lanes` is 0 before the swap. After the swap, with ch 0 and bits 11..0 read, `rd_lanes[0]`=1 for every bit and all other lanes = 0. `frame_count`=1.
- `frame_sync` while in FILL, repeated 300 times → `repeat_count`=255, `frame_count` unchanged, no swap.
- Accept `wr_last`, then hold `wr_valid` with new data → `wr_ready`=0 and nothing is written until `frame_sync`. `wr_ready`=1 on the cycle after.
- Write lane 13 ch 2 = 0xABC → `wr_error`=1, and no lane 0–11 location changes.
- `wr_last` acceptance and `frame_sync` in the same cycle → no swap and `repeat_count`+1. The next `frame_sync` swaps.
- Lane 5 ch 7 = 0x5A3 displayed, read at bit 11 down to 0 → `rd_lanes[5]` follows 0101_1010_0011 with 1-cycle latency. Then assert `reset_n`=0 in PENDING → all outputs return to reset values, and the next `frame_sync` does not swap.

Source files
------------

// File: rtl/nx4_pkg.sv
// Shared NX4 panel constants.
// Holds the frame geometry (lanes, channels, grayscale depth), the field
// widths used on the write and read buses, the frame-ownership FSM
// encodings, and the lane-to-SIN mapping that the driver stage also uses.
package nx4_pkg;

  localparam int LANES    = 12;
  localparam int CHANNELS = 16;
  localparam int GS_BITS  = 12;

  localparam int LANE_W = 4;
  localparam int CH_W   = 4;
  localparam int BIT_W  = 4;

  // Lanes 0-5 drive left SIN 1-6, lanes 6-11 drive right SIN 1-6.
  localparam int SIN_PER_SIDE    = 6;
  localparam int LEFT_LANE_BASE  = 0;
  localparam int RIGHT_LANE_BASE = 6;

  localparam logic [0:0] ST_FILL    = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  function automatic logic lane_is_right(input logic [LANE_W-1:0] lane);
    return lane >= LANE_W'(RIGHT_LANE_BASE);
  endfunction

  // 1-based SIN pin number on the lane's side of the panel.
  function automatic logic [2:0] lane_sin(input logic [LANE_W-1:0] lane);
    if (lane_is_right(lane))
      return 3'(lane - LANE_W'(RIGHT_LANE_BASE) + 4'd1);
    return 3'(lane - LANE_W'(LEFT_LANE_BASE) + 4'd1);
  endfunction

endpackage

// File: rtl/pixel_frame_buffer_if.sv
// Grayscale write bus into the frame buffer.
// master: pattern/host side, drives wr_valid, wr_lane, wr_channel, wr_data,
//         wr_last and observes wr_ready.
// slave:  frame buffer, observes the request and drives wr_ready.
interface pixel_frame_buffer_if;
  import nx4_pkg::*;

  logic               wr_valid;
  logic               wr_ready;
  logic [LANE_W-1:0]  wr_lane;
  logic [CH_W-1:0]    wr_channel;
  logic [GS_BITS-1:0] wr_data;
  logic               wr_last;

  modport master (
    output wr_valid, wr_lane, wr_channel, wr_data, wr_last,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_lane, wr_channel, wr_data, wr_last,
    output wr_ready
  );

endinterface

// File: rtl/gs_lane_ram.sv
// Per-lane grayscale store: 2 banks x CHANNELS words of GS_BITS.
// Ports:
//   clock             rising-edge clock
//   wr_en/wr_bank/wr_addr/wr_data   synchronous write port
//   rd_bank/rd_addr   read address, sampled on the clock edge
//   rd_data           registered full word, valid one cycle after the address
module gs_lane_ram
  import nx4_pkg::*;
(
  input  logic               clock,
  input  logic               wr_en,
  input  logic               wr_bank,
  input  logic [CH_W-1:0]    wr_addr,
  input  logic [GS_BITS-1:0] wr_data,
  input  logic               rd_bank,
  input  logic [CH_W-1:0]    rd_addr,
  output logic [GS_BITS-1:0] rd_data
);

  logic [GS_BITS-1:0] mem [2*CHANNELS];

  always_ff @(posedge clock) begin
    if (wr_en)
      mem[{wr_bank, wr_addr}] <= wr_data;
    rd_data <= mem[{rd_bank, rd_addr}];
  end

endmodule

// File: rtl/pixel_frame_buffer.sv
// Double-buffered grayscale frame store for the NX4 pixel driver.
// Ports:
//   clock, reset_n   clock and synchronous active-low reset
//   bus              write bus (slave side): lane/channel/data/last + handshake
//   frame_sync       driver latch-boundary pulse; swaps banks when a frame is pending
//   rd_channel/rd_bit  bit the driver is shifting (rd_bit 11 = MSB)
//   rd_lanes         selected bit of every lane from the display bank, 1-cycle latency
//   frame_count      completed bank swaps (wraps)
//   repeat_count     frame_syncs with no pending frame (saturates at 255)
//   wr_error         sticky: a write targeted a lane beyond the panel
module pixel_frame_buffer
  import nx4_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  pixel_frame_buffer_if.slave bus,
  input  logic              frame_sync,
  input  logic [CH_W-1:0]   rd_channel,
  input  logic [BIT_W-1:0]  rd_bit,
  output logic [LANES-1:0]  rd_lanes,
  output logic [15:0]       frame_count,
  output logic [7:0]        repeat_count,
  output logic              wr_error
);

  logic [0:0] state;
  logic       disp_sel;
  logic       frame_valid;
  logic       accept;
  logic       lane_ok;

  logic [GS_BITS-1:0] rd_word_p0 [LANES];
  logic [BIT_W-1:0]   rd_bit_p0;
  logic               vld_p0;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign bus.wr_ready = reset_n & (state == ST_FILL);
  assign accept       = bus.wr_valid & bus.wr_ready;
  assign lane_ok      = bus.wr_lane < LANE_W'(LANES);

  // Ownership FSM. frame_sync is judged against the registered state, so a
  // commit landing on the same edge as frame_sync waits for the next one.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= ST_FILL;
      disp_sel     <= 1'b0;
      frame_valid  <= 1'b0;
      frame_count  <= 16'd0;
      repeat_count <= 8'd0;
      wr_error     <= 1'b0;
    end else begin
      if (accept && !lane_ok)
        wr_error <= 1'b1;
      case (state)
        ST_FILL: begin
          if (accept && bus.wr_last)
            state <= ST_PENDING;
          if (frame_sync)
            repeat_count <= sat_inc8(repeat_count);
        end
        default: begin
          if (frame_sync) begin
            disp_sel    <= ~disp_sel;
            frame_count <= frame_count + 16'd1;
            frame_valid <= 1'b1;
            state       <= ST_FILL;
          end
        end
      endcase
    end
  end

  // Stage p0: per-lane word read from the display bank. Lanes >= LANES never
  // match any instance, so out-of-range writes fall on the floor here.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    gs_lane_ram u_ram (
      .clock   (clock),
      .wr_en   (accept && (bus.wr_lane == LANE_W'(i))),
      .wr_bank (~disp_sel),
      .wr_addr (bus.wr_channel),
      .wr_data (bus.wr_data),
      .rd_bank (disp_sel),
      .rd_addr (rd_channel),
      .rd_data (rd_word_p0[i])
    );
  end

  // The gate travels with the read, so a read taken before the first swap
  // stays dark even though it emerges after frame_valid has risen.
  always_ff @(posedge clock) begin
    rd_bit_p0 <= rd_bit;
    if (!reset_n)
      vld_p0 <= 1'b0;
    else
      vld_p0 <= frame_valid;
  end

  always_comb begin
    rd_lanes = '0;
    for (int i = 0; i < LANES; i++) begin
      if (vld_p0 && (rd_bit_p0 < BIT_W'(GS_BITS)))
        rd_lanes[i] = rd_word_p0[i][rd_bit_p0];
    end
  end

endmodule

// File: tb/tb_pixel_frame_buffer.sv
module tb_pixel_frame_buffer;
  import nx4_pkg::*;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              frame_sync;
  logic [CH_W-1:0]   rd_channel;
  logic [BIT_W-1:0]  rd_bit;
  logic [LANES-1:0]  rd_lanes;
  logic [15:0]       frame_count;
  logic [7:0]        repeat_count;
  logic              wr_error;

  pixel_frame_buffer_if bus ();

  pixel_frame_buffer dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .bus          (bus),
    .frame_sync   (frame_sync),
    .rd_channel   (rd_channel),
    .rd_bit       (rd_bit),
    .rd_lanes     (rd_lanes),
    .frame_count  (frame_count),
    .repeat_count (repeat_count),
    .wr_error     (wr_error)
  );

  always #5 clock = ~clock;

  // Reference model: two banks of words, who is displayed, whether a
  // committed frame is waiting, and the counters.
  logic [11:0] m_mem   [2][12][16];
  bit          m_known [2][12][16];
  bit          m_pending, m_disp, m_fvalid, m_err;
  int          m_fc, m_rc;
  logic [11:0] m_rd, m_mask;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    bit          acc, nxt_pending;
    logic [11:0] w;
    int          ln, ch;
    @(posedge clock);
    if (!reset_n) begin
      m_pending = 0; m_disp = 0; m_fvalid = 0; m_err = 0;
      m_fc = 0; m_rc = 0; m_rd = '0; m_mask = '1;
    end else begin
      m_rd = '0; m_mask = '1;
      if (m_fvalid && rd_bit < 12) begin
        for (int i = 0; i < 12; i++) begin
          if (m_known[m_disp][i][rd_channel]) begin
            w = m_mem[m_disp][i][rd_channel];
            m_rd[i] = w[rd_bit];
          end else begin
            m_mask[i] = 1'b0;
          end
        end
      end
      acc = bus.wr_valid && !m_pending;
      nxt_pending = m_pending;
      if (acc) begin
        ln = int'(bus.wr_lane);
        ch = int'(bus.wr_channel);
        if (ln < 12) begin
          m_mem[!m_disp][ln][ch]   = bus.wr_data;
          m_known[!m_disp][ln][ch] = 1;
        end else begin
          m_err = 1;
        end
        if (bus.wr_last) nxt_pending = 1;
      end
      if (frame_sync) begin
        if (m_pending) begin
          m_disp = !m_disp;
          m_fc = (m_fc + 1) % 65536;
          m_fvalid = 1;
          nxt_pending = 0;
        end else if (m_rc < 255) begin
          m_rc++;
        end
      end
      m_pending = nxt_pending;
    end
    #1;
    chk("wr_ready", 32'(bus.wr_ready), 32'(reset_n && !m_pending));
    chk("rd_lanes", 32'(rd_lanes & m_mask), 32'(m_rd & m_mask));
    chk("frame_count", 32'(frame_count), 32'(m_fc));
    chk("repeat_count", 32'(repeat_count), 32'(m_rc));
    chk("wr_error", 32'(wr_error), 32'(m_err));
  endtask

  task automatic idle_inputs();
    bus.wr_valid = 0; bus.wr_last = 0; bus.wr_lane = '0;
    bus.wr_channel = '0; bus.wr_data = '0; frame_sync = 0;
  endtask

  task automatic wr(input int lane, input int ch, input int data, input bit last);
    bus.wr_valid   = 1;
    bus.wr_lane    = 4'(lane);
    bus.wr_channel = 4'(ch);
    bus.wr_data    = 12'(data);
    bus.wr_last    = last;
    tick();
    bus.wr_valid = 0;
    bus.wr_last  = 0;
  endtask

  task automatic sync1();
    frame_sync = 1;
    tick();
    frame_sync = 0;
  endtask

  task automatic do_reset(input int n);
    reset_n = 0;
    repeat (n) tick();
    reset_n = 1;
  endtask

  task automatic read_word(input int lane, input int ch, output logic [11:0] w);
    rd_channel = 4'(ch);
    w = '0;
    for (int b = 11; b >= 0; b--) begin
      rd_bit = 4'(b);
      tick();
      w[b] = rd_lanes[lane];
    end
  endtask

  logic [11:0] word;
  logic [11:0] pat;

  initial begin
    reset_n = 0;
    rd_channel = '0;
    rd_bit = '0;
    idle_inputs();
    for (int b = 0; b < 2; b++)
      for (int l = 0; l < 12; l++)
        for (int c = 0; c < 16; c++)
          m_known[b][l][c] = 0;

    // Reset state.
    do_reset(3);
    chk("rst_ready_low", 32'(bus.wr_ready), 32'd0);
    tick();
    chk("post_rst_ready", 32'(bus.wr_ready), 32'd1);

    // Zero both banks so every later read has a defined value.
    for (int pass = 0; pass < 2; pass++) begin
      for (int l = 0; l < 12; l++)
        for (int c = 0; c < 16; c++)
          wr(l, c, 0, (l == 11) && (c == 15));
      sync1();
    end

    // Single full-scale pixel on lane 0 channel 0.
    do_reset(2);
    wr(0, 0, 12'hFFF, 1);
    chk("t1_ready_fall", 32'(bus.wr_ready), 32'd0);
    rd_channel = 0; rd_bit = 4'd11;
    tick();
    chk("t1_dark", 32'(rd_lanes), 32'd0);
    sync1();
    chk("t1_dark_sync", 32'(rd_lanes), 32'd0);
    chk("t1_ready_rise", 32'(bus.wr_ready), 32'd1);
    for (int b = 11; b >= 0; b--) begin
      rd_bit = 4'(b);
      tick();
      chk("t1_bit", 32'(rd_lanes), 32'h001);
    end
    chk("t1_fc", 32'(frame_count), 32'd1);

    // Repeated frame_sync with nothing committed.
    repeat (300) sync1();
    chk("t2_rc_sat", 32'(repeat_count), 32'd255);
    chk("t2_fc_hold", 32'(frame_count), 32'd1);

    // Writes held off while a frame is pending.
    wr(1, 3, 12'h123, 1);
    bus.wr_valid = 1; bus.wr_lane = 4'd1; bus.wr_channel = 4'd3; bus.wr_data = 12'h456;
    repeat (5) begin
      tick();
      chk("t3_ready_low", 32'(bus.wr_ready), 32'd0);
    end
    frame_sync = 1;
    tick();
    frame_sync = 0;
    bus.wr_valid = 0;
    chk("t3_ready_rise", 32'(bus.wr_ready), 32'd1);
    read_word(1, 3, word);
    chk("t3_word", 32'(word), 32'h123);

    // Out-of-range lane.
    wr(13, 2, 12'hABC, 1);
    chk("t4_err", 32'(wr_error), 32'd1);
    sync1();
    for (int l = 0; l < 12; l += 5) begin
      read_word(l, 2, word);
      chk("t4_lane_clean", 32'(word), 32'(m_mem[m_disp][l][2]));
    end

    // Commit and frame_sync on the same edge.
    do_reset(1);
    bus.wr_valid = 1; bus.wr_lane = 4'd4; bus.wr_channel = 4'd9;
    bus.wr_data = 12'h7E1; bus.wr_last = 1; frame_sync = 1;
    tick();
    idle_inputs();
    chk("t5_rc", 32'(repeat_count), 32'd1);
    chk("t5_no_swap", 32'(frame_count), 32'd0);
    sync1();
    chk("t5_swap", 32'(frame_count), 32'd1);
    read_word(4, 9, word);
    chk("t5_word", 32'(word), 32'h7E1);

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      bus.wr_valid   = 1'($urandom_range(0, 1));
      bus.wr_lane    = 4'($urandom_range(0, 13));
      bus.wr_channel = 4'($urandom_range(0, 15));
      bus.wr_data    = 12'($urandom);
      bus.wr_last    = ($urandom_range(0, 30) == 0);
      frame_sync     = ($urandom_range(0, 7) == 0);
      rd_channel     = 4'($urandom_range(0, 15));
      rd_bit         = 4'($urandom_range(0, 15));
      tick();
    end
    idle_inputs();

    // Bit-serial readout, then reset while pending.
    do_reset(1);
    wr(5, 7, 12'h5A3, 1);
    sync1();
    pat = 12'h5A3;
    rd_channel = 4'd7;
    for (int b = 11; b >= 0; b--) begin
      rd_bit = 4'(b);
      tick();
      chk("t6_lane5", 32'(rd_lanes[5]), 32'(pat[b]));
    end
    wr(0, 0, 12'h111, 1);
    chk("t6_pending", 32'(bus.wr_ready), 32'd0);
    reset_n = 0;
    tick();
    chk("t6_rst_rd", 32'(rd_lanes), 32'd0);
    chk("t6_rst_fc", 32'(frame_count), 32'd0);
    chk("t6_rst_ready", 32'(bus.wr_ready), 32'd0);
    reset_n = 1;
    tick();
    sync1();
    chk("t6_no_swap", 32'(frame_count), 32'd0);
    chk("t6_rc", 32'(repeat_count), 32'd1);
    tick();
    chk("t6_dark", 32'(rd_lanes), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
